aes_round_sequencer: RTL

Round-sequencing controller for the AES Cipher/Decipher datapaths. It accepts a start request with a key size (128/192/256) and a mode (encrypt, decrypt, or encrypt-then-decrypt), then drives the shared round index and phase into the datapaths. It advances either every clock or once per debounced push-button step, and reports busy/done/err to the board top level. It replaces the free-running round counter in the top level with a proper handshaked FSM.

---
 rtl/aes_seq_pkg.sv | 32 +++
 rtl/step_edge_detect.sv | 21 ++
 rtl/aes_round_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/aes_seq_pkg.sv
// Shared encodings for the AES round sequencer: key sizes, modes, round counts
// and FSM states.
package aes_seq_pkg;

  localparam logic [1:0] KS_128 = 2'd0;
  localparam logic [1:0] KS_192 = 2'd1;
  localparam logic [1:0] KS_256 = 2'd2;

  localparam logic [1:0] MODE_ENC     = 2'd0;
  localparam logic [1:0] MODE_DEC     = 2'd1;
  localparam logic [1:0] MODE_ENC_DEC = 2'd2;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Illegal code 3 is never latched, so its mapping is irrelevant.
  function automatic logic [3:0] nr_of(input logic [1:0] ks);
    case (ks)
      KS_128:  nr_of = NR_128;
      KS_192:  nr_of = NR_192;
      default: nr_of = NR_256;
    endcase
  endfunction

endpackage

// File: rtl/step_edge_detect.sv
// Registers a clk-synchronous strobe and emits a one-cycle pulse on its
// low-to-high transition.
module step_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // NOTE: sequential state is always written with non-blocking (<=) so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/aes_round_sequencer.sv
// Handshaked round/phase sequencer shared by the AES cipher and decipher
// datapaths; advances every clock or once per single-step press.
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int ROUND_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         key_size,
  input  logic [1:0]         mode,
  input  logic               step_mode,
  input  logic               step,
  output logic               busy,
  output logic [ROUND_W-1:0] round,
  output logic               phase,
  output logic [3:0]         nr,
  output logic               done,
  output logic               err
);

  if (ROUND_W < 4) begin : g_bad_round_w
    $error("aes_round_sequencer: ROUND_W must be at least 4 to hold round 14");
  end

  seq_state_e         state_q;
  logic [1:0]         ks_q;
  logic [1:0]         mode_q;
  logic [ROUND_W-1:0] round_q;
  logic               phase_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic               step_rise;
  logic               adv;
  logic [ROUND_W-1:0] nr_ext;

  step_edge_detect u_step_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (step),
    .rise_o (step_rise)
  );

  assign adv    = step_mode ? step_rise : 1'b1;
  assign nr     = nr_of(ks_q);
  assign nr_ext = ROUND_W'(nr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ks_q    <= KS_128;
      mode_q  <= MODE_ENC;
      round_q <= '0;
      phase_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (key_size == 2'd3 || mode == 2'd3) begin
              err_q <= 1'b1;
            end else begin
              ks_q    <= key_size;
              mode_q  <= mode;
              round_q <= '0;
              phase_q <= (mode == MODE_DEC);
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Abort deliberately outranks a same-cycle advance.
          if (abort) begin
            round_q <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (adv) begin
            if (round_q < nr_ext) begin
              round_q <= round_q + ROUND_W'(1);
            end else if (!phase_q && mode_q == MODE_ENC_DEC) begin
              phase_q <= 1'b1;
              round_q <= '0;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (abort) begin
            round_q <= '0;
            phase_q <= 1'b0;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign round = round_q;
  assign phase = phase_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule
